// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO between the CPU memory stage and the
// 16-bit data memory. Loads take the DM port ahead of buffered stores unless
// the buffer is full.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding; when
// undefined, loads stall until the buffer is empty).
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_ready,
    output logic [DW-1:0] ld_data,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    input  logic [DW-1:0] dm_dout,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic full;
    logic push;
    logic drain;
    logic ld_grant;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    // No bypass into a full buffer, even when a drain retires an entry this cycle.
    assign st_ready = !full;

`ifdef STORE_FWD_EN
    assign ld_ready = !full;
`else
    assign ld_ready = empty;
`endif

    assign ld_grant = ld_valid & ld_ready;
    assign drain    = !ld_grant & !empty;
    assign push     = st_valid & st_ready;

    // DM port mux: a granted load owns the port, otherwise the head entry drains.
    always_comb begin
        dm_addr = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        if (ld_grant) begin
            dm_addr = ld_addr;
        end else if (drain) begin
            dm_addr = ent_addr[rd_ptr];
            dm_din  = ent_data[rd_ptr];
            dm_we   = 1'b1;
        end
    end

`ifdef STORE_FWD_EN
    logic [PW-1:0] idx;

    // Youngest-match forwarding: scanning oldest to youngest and letting later
    // hits overwrite gives the same result as searching back from wr_ptr-1.
    always_comb begin
        ld_data = dm_dout;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (ent_addr[idx] == ld_addr)) begin
                ld_data = ent_data[idx];
            end
        end
    end
`else
    // Without forwarding, loads only complete once every store has reached DM.
    assign ld_data = dm_dout;
`endif

    // Pointer and occupancy update; reset discards all pending stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= st_addr;
            ent_data[wr_ptr] <= st_data;
        end
    end

endmodule
